vid_pattern_gen: RTL and testbench
==================================

Name: vid_pattern_gen

Overview:
- Synthesizable, parametrised video timing and test-pattern source for the vp pipeline.
- Drives the same de/hs/vs plus 3-channel pixel interface that downstream processing IPs consume.
- Generalises the fixed-resolution simulation source: per-channel width, programmable porches and sync polarity, four pattern modes, run/stop control and frame counting.
- Sits at the head of the pipeline for board bring-up and regression, in place of a camera or HDMI receiver.

Parameters:
- H_RES, 64, active pixels per line; must be a multiple of 8.
- H_FP, 8, horizontal front porch (cycles after active).
- H_SYNC, 2, hsync length.
- H_BP, 8, horizontal back porch (cycles after sync).
- V_RES, 64, active lines per frame.
- V_FP, 8, vertical front porch (lines).
- V_SYNC, 4, vsync length (lines).
- V_BP, 8, vertical back porch (lines).
- HS_POL, 1, hsync active level.
- VS_POL, 1, vsync active level.
- PIX_W, 8, bits per colour channel.
- CHK_LOG2, 3, checkerboard cell size is 2^CHK_LOG2 pixels.

Ports:
- clk  in  1  pixel clock; everything is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = generate frames.
- mode  in  2  pattern select: 0 colour bars, 1 horizontal ramp, 2 checkerboard, 3 solid.
- solid_rgb  in  3*PIX_W  solid colour {r,g,b}; used in mode 3.
- vid_de  out  1  data enable.
- vid_hs  out  1  hsync (HS_POL).
- vid_vs  out  1  vsync (VS_POL).
- vid_r / vid_g / vid_b  out  PIX_W each  pixel data.
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) de.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  completed frames; wraps at 0xFFFF->0.

Behaviour:
- Reset values (applied immediately on rst_n low, including mid-frame):
  - vid_de=0, frame_start=0, busy=0, frame_cnt=0, vid_r/g/b=0.
  - vid_hs=!HS_POL, vid_vs=!VS_POL.
  - Counters at 0; FSM in IDLE.
- Timing:
  - H_TOTAL=H_RES+H_FP+H_SYNC+H_BP; V_TOTAL=V_RES+V_FP+V_SYNC+V_BP.
  - h_cnt runs 0..H_TOTAL-1; v_cnt increments when h_cnt wraps, and runs 0..V_TOTAL-1.
  - Active region: h_cnt<H_RES and v_cnt<V_RES.
  - hs active for H_RES+H_FP <= h_cnt < H_RES+H_FP+H_SYNC.
  - vs active for V_RES+V_FP <= v_cnt < V_RES+V_FP+V_SYNC, for whole lines (it changes at h_cnt=0).
- Outputs: all registered, one register stage after the counters; de, hs, vs and rgb are mutually aligned.
- FSM:
  - IDLE: counters held at 0; outputs at reset values except frame_cnt, which holds. run=1 -> RUN with counters (0,0).
  - RUN: free-running. run=0 -> DRAIN.
  - DRAIN: continues; if run returns to 1 -> RUN. At the last cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1) -> IDLE. No partial frames are ever emitted.
- Latency: run sampled high in IDLE at edge N; first vid_de=1 and frame_start=1 after edge N+1.
- Frame boundary: mode and solid_rgb are latched when counters are at (0,0). A mode change mid-frame takes effect on the next frame only.
- frame_cnt increments on the last cycle of each frame, including the frame that DRAIN completes.
- Patterns:
  - Inactive region: rgb=0.
  - Bars: 8 bars, each H_RES/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. Full scale = all ones.
  - Ramp: r=g=b=h_cnt[PIX_W-1:0], wrapping; pixel 0 has value 0.
  - Checker: white where h_cnt[CHK_LOG2]^v_cnt[CHK_LOG2]=1, else black; cell (0,0) is black.
  - Solid: latched solid_rgb.
- Simultaneous events: run falling on the last cycle of a frame -> IDLE at the next edge.

Optional Feature:
- Macro: VID_PATTERN_SCROLL_EN.
- When defined: the x coordinate used for bars, ramp and checker is (h_cnt + frame_cnt) mod H_RES, so the pattern scrolls left one pixel per frame. Mode 3 and all timing are unaffected.
- When undefined: x = h_cnt; there is no extra adder.

Decomposition:
- Package vid_pkg:
  - mode enum (VP_BARS, VP_RAMP, VP_CHECK, VP_SOLID).
  - FSM state enum (IDLE, RUN, DRAIN).
  - Bar colour table as 8 x 3-bit on/off constants.
- One sub-module, vid_timing_cnt: h/v counters plus active/hs/vs decode.
- Pattern mux, FSM and output registers live in the top.

Test Plan:
- Params H_RES=8, H_FP=2, H_SYNC=1, H_BP=2, V_RES=4, V_FP=V_SYNC=V_BP=1, mode=0, run held 1 -> H_TOTAL=13 and a 91-cycle frame. Expect 8 de cycles per line, hs low-active absent (HS_POL=1, so high) for exactly 1 cycle at line offset 10, and vs high for 13 cycles. frame_start spacing is 91; bar pixel values are FF FF FF, FF FF 00, 00 FF FF, ....
- Mode 1 with H_RES=64: line pixels 0..63 are 0x00..0x3F. Mode 2 with CHK_LOG2=3: pixel (8,0) is FF, (8,8) is 00.
- Deassert run at mid-frame cycle 40 -> de continues to frame end, busy falls 1 cycle after, frame_cnt increments by 1, no further de.
- Change mode 0->3 with solid_rgb=0x123456 mid-frame -> current frame stays bars; next frame is all 12/34/56.
- Assert rst_n=0 asynchronously mid-active-line -> outputs at reset values before the next edge. Release with run=1 -> frame_start 2 edges later and frame_cnt=0.
- With VID_PATTERN_SCROLL_EN, mode 1 -> frame k pixel 0 value equals k mod 8 (H_RES=8).

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and constants for the vid_pattern_gen video source:
// pattern modes, FSM states and the colour-bar on/off table.
package vid_pkg;

  typedef enum logic [1:0] {
    VP_BARS  = 2'd0,
    VP_RAMP  = 2'd1,
    VP_CHECK = 2'd2,
    VP_SOLID = 2'd3
  } vp_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vp_state_e;

  // {r,g,b} on/off per bar, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_ON [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                        3'b101, 3'b100, 3'b001, 3'b000};

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counters with active-region, sync and end-of-frame decode.
module vid_timing_cnt #(
  parameter int H_RES  = 64,
  parameter int H_FP   = 8,
  parameter int H_SYNC = 2,
  parameter int H_BP   = 8,
  parameter int V_RES  = 64,
  parameter int V_FP   = 8,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           i_adv,
  output logic [$clog2(H_RES+H_FP+H_SYNC+H_BP)-1:0]      o_h_cnt,
  output logic [$clog2(V_RES+V_FP+V_SYNC+V_BP)-1:0]      o_v_cnt,
  output logic                                           o_active,
  output logic                                           o_hs,
  output logic                                           o_vs,
  output logic                                           o_last
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (32'(r_h_cnt) == H_TOTAL - 1);
  assign w_v_last = (32'(r_v_cnt) == V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_adv) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // vs is decoded from v_cnt alone, so it spans whole lines and changes at h_cnt=0
  assign o_active = (32'(r_h_cnt) < H_RES) && (32'(r_v_cnt) < V_RES);
  assign o_hs     = (32'(r_h_cnt) >= H_RES + H_FP) && (32'(r_h_cnt) < H_RES + H_FP + H_SYNC);
  assign o_vs     = (32'(r_v_cnt) >= V_RES + V_FP) && (32'(r_v_cnt) < V_RES + V_FP + V_SYNC);
  assign o_last   = w_h_last && w_v_last;
  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;

endmodule

// File: rtl/vid_pattern_gen.sv
// Video timing and test-pattern source: run/drain FSM, pattern mux and registered outputs.
// Define VID_PATTERN_SCROLL_EN to scroll bars/ramp/checker left one pixel per frame.
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int H_RES    = 64,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 2,
  parameter int H_BP     = 8,
  parameter int V_RES    = 64,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 8,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIX_W    = 8,
  parameter int CHK_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [1:0]         mode,
  input  logic [3*PIX_W-1:0] solid_rgb,
  output logic               vid_de,
  output logic               vid_hs,
  output logic               vid_vs,
  output logic [PIX_W-1:0]   vid_r,
  output logic [PIX_W-1:0]   vid_g,
  output logic [PIX_W-1:0]   vid_b,
  output logic               frame_start,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int HW = $clog2(H_RES + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_RES + V_FP + V_SYNC + V_BP);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [HW-1:0]      w_h;
  logic [VW-1:0]      w_v;
  logic               w_active, w_hs, w_vs, w_last, w_origin, w_adv;
  logic [1:0]         r_mode, w_mode;
  logic [3*PIX_W-1:0] r_solid, w_solid;
  logic [31:0]        w_x;
  logic [2:0]         w_on;
  logic               w_chk;
  logic [3*PIX_W-1:0] w_pix;
  logic               r_de, r_hs, r_vs, r_fs;
  logic [3*PIX_W-1:0] r_rgb;
  logic [15:0]        r_frame_cnt;

  assign w_adv = (r_state != ST_IDLE);

  vid_timing_cnt #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (w_adv),
    .o_h_cnt (w_h),
    .o_v_cnt (w_v),
    .o_active(w_active),
    .o_hs    (w_hs),
    .o_vs    (w_vs),
    .o_last  (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (run) w_state_next = ST_RUN;
      ST_RUN:   if (!run) w_state_next = w_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (run) w_state_next = ST_RUN;
                else if (w_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Pixel (0,0) sees the live inputs; the rest of the frame uses the copy latched there
  assign w_origin = (w_h == '0) && (w_v == '0);
  assign w_mode   = w_origin ? mode      : r_mode;
  assign w_solid  = w_origin ? solid_rgb : r_solid;

`ifdef VID_PATTERN_SCROLL_EN
  assign w_x = (32'(w_h) + 32'(r_frame_cnt)) % 32'(H_RES);
`else
  assign w_x = 32'(w_h);
`endif

  assign w_on  = BAR_ON[3'(w_x / 32'(H_RES / 8))];
  assign w_chk = 1'(w_x >> CHK_LOG2) ^ 1'(32'(w_v) >> CHK_LOG2);

  always_comb begin
    w_pix = '0;
    case (w_mode)
      VP_BARS:  w_pix = {{PIX_W{w_on[2]}}, {PIX_W{w_on[1]}}, {PIX_W{w_on[0]}}};
      VP_RAMP:  w_pix = {3{PIX_W'(w_x)}};
      VP_CHECK: w_pix = {(3*PIX_W){w_chk}};
      VP_SOLID: w_pix = w_solid;
      default:  w_pix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_solid     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_origin) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
      end
      if (w_adv && w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de  <= 1'b0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_fs  <= 1'b0;
      r_rgb <= '0;
    end else if (!w_adv) begin
      r_de  <= 1'b0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_fs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de  <= w_active;
      r_hs  <= w_hs ? HS_POL : ~HS_POL;
      r_vs  <= w_vs ? VS_POL : ~VS_POL;
      r_fs  <= w_origin;
      r_rgb <= w_active ? w_pix : '0;
    end
  end

  assign vid_de      = r_de;
  assign vid_hs      = r_hs;
  assign vid_vs      = r_vs;
  assign vid_r       = r_rgb[3*PIX_W-1:2*PIX_W];
  assign vid_g       = r_rgb[2*PIX_W-1:PIX_W];
  assign vid_b       = r_rgb[PIX_W-1:0];
  assign frame_start = r_fs;
  assign busy        = (r_state != ST_IDLE);
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Self-checking bench for vid_pattern_gen against a frame-level reference model.
module tb_vid_pattern_gen;

  localparam int H_RES = 8, H_FP = 2, H_SYNC = 1, H_BP = 2;
  localparam int V_RES = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b1;
  localparam int PIX_W = 8, CHK_LOG2 = 1;
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOTAL * V_TOTAL;
`ifdef VID_PATTERN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  localparam logic [44:0] IDLE_VEC = {1'b0, !HS_POL, !VS_POL, 1'b0, 1'b0, 24'h0, 16'h0};

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic vid_de, vid_hs, vid_vs, frame_start, busy;
  logic [7:0] vid_r, vid_g, vid_b;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: frame-level view of the source
  bit          m_act = 1'b0;
  int          m_pos = 0;
  int          m_fc = 0;
  int          m_mode = 0;
  logic [23:0] m_solid = 24'h0;

  vid_pattern_gen #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_W(PIX_W), .CHK_LOG2(CHK_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .solid_rgb(solid_rgb),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_pixel(input int h, input int v, input int md,
                                              input logic [23:0] sol, input int fc);
    int x;
    x = SCROLL ? (h + fc) % H_RES : h;
    case (md)
      0: return BARS[x / (H_RES / 8)];
      1: return {3{8'(x)}};
      2: return ((((x >> CHK_LOG2) ^ (v >> CHK_LOG2)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return sol;
    endcase
  endfunction

  function automatic logic [44:0] dut_vec();
    return {vid_de, vid_hs, vid_vs, frame_start, busy, vid_r, vid_g, vid_b, frame_cnt};
  endfunction

  task automatic model_reset();
    m_act = 1'b0;
    m_pos = 0;
    m_fc  = 0;
  endtask

  // One clock: predict the registered outputs, advance the model, compare after the edge
  task automatic step(input string tag);
    logic e_de, e_hs, e_vs, e_fs;
    logic [23:0] pix;
    logic [44:0] exp_v;
    int h, v;
    e_de = 1'b0; e_hs = !HS_POL; e_vs = !VS_POL; e_fs = 1'b0; pix = 24'h0;
    if (m_act) begin
      h = m_pos % H_TOTAL;
      v = m_pos / H_TOTAL;
      if (m_pos == 0) begin
        m_mode  = int'(mode);
        m_solid = solid_rgb;
      end
      e_de = (h < H_RES) && (v < V_RES);
      e_hs = (h >= H_RES + H_FP && h < H_RES + H_FP + H_SYNC) ? HS_POL : !HS_POL;
      e_vs = (v >= V_RES + V_FP && v < V_RES + V_FP + V_SYNC) ? VS_POL : !VS_POL;
      e_fs = (m_pos == 0);
      if (e_de) pix = model_pixel(h, v, m_mode, m_solid, m_fc);
      if (m_pos == FRAME - 1) begin
        m_fc  = (m_fc + 1) & 16'hFFFF;
        m_act = run;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end else if (run) begin
      m_act = 1'b1;
      m_pos = 0;
    end
    @(posedge clk);
    #1;
    exp_v = {e_de, e_hs, e_vs, e_fs, m_act, pix, 16'(m_fc)};
    total++;
    if (dut_vec() !== exp_v) begin
      bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, dut_vec(), exp_v);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (dut_vec() !== IDLE_VEC) begin
      bad++;
      $display("FAIL reset_state got=%h expected=%h", dut_vec(), IDLE_VEC);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (5) step("idle_hold");
    $display("test_reset: done");
  endtask

  task automatic test_bars();
    int cyc = 0, fs1 = -1, fs2 = -1, de_n = 0, vs_n = 0;
    mode = 2'd0;
    run  = 1'b1;
    repeat (2 * FRAME + 2) begin
      step("bars");
      cyc++;
      if (frame_start) begin
        if (fs1 < 0) fs1 = cyc;
        else if (fs2 < 0) fs2 = cyc;
      end
      if (fs1 >= 0 && fs2 < 0) begin
        if (vid_de) de_n++;
        if (vid_vs == VS_POL) vs_n++;
      end
    end
    total++;
    if (fs2 - fs1 != FRAME) begin
      bad++;
      $display("FAIL fs_spacing got=%0d expected=%0d", fs2 - fs1, FRAME);
    end
    total++;
    if (de_n != H_RES * V_RES) begin
      bad++;
      $display("FAIL de_per_frame got=%0d expected=%0d", de_n, H_RES * V_RES);
    end
    total++;
    if (vs_n != V_SYNC * H_TOTAL) begin
      bad++;
      $display("FAIL vs_cycles got=%0d expected=%0d", vs_n, V_SYNC * H_TOTAL);
    end
    $display("test_bars: frames=%0d", m_fc);
  endtask

  task automatic test_drain();
    int fc_exp, de_n = 0;
    for (int i = 0; i < FRAME && m_pos != 40; i++) step("drain_seek");
    run = 1'b0;
    fc_exp = (m_fc + 1) & 16'hFFFF;
    repeat (FRAME) step("drain");
    total++;
    if (frame_cnt !== 16'(fc_exp) || busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_end got=%0d/%0b expected=%0d/0", frame_cnt, busy, fc_exp);
    end
    repeat (20) begin
      step("drain_idle");
      if (vid_de) de_n++;
    end
    total++;
    if (de_n != 0) begin
      bad++;
      $display("FAIL drain_no_de got=%0d expected=0", de_n);
    end
    $display("test_drain: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_mode_change();
    int fc0, n = 0;
    mode = 2'd0;
    run  = 1'b1;
    repeat (30) step("mode_pre");
    fc0 = m_fc;
    mode = 2'd3;
    solid_rgb = 24'h123456;
    for (int i = 0; i < 3 * FRAME && m_fc != fc0 + 2; i++) begin
      step("mode_chg");
      if (vid_de && {vid_r, vid_g, vid_b} == 24'h123456) n++;
    end
    total++;
    if (n != H_RES * V_RES) begin
      bad++;
      $display("FAIL mode_next_frame got=%0d expected=%0d", n, H_RES * V_RES);
    end
    $display("test_mode_change: solid pixels=%0d", n);
  endtask

  task automatic test_simultaneous();
    mode = 2'd2;
    run  = 1'b1;
    for (int i = 0; i < FRAME && m_pos != FRAME - 1; i++) step("simul_seek");
    run = 1'b0;
    step("simul_last");
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL simul_idle got=%0b expected=0", busy);
    end
    repeat (5) step("simul_after");
    $display("test_simultaneous: done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) solid_rgb = 24'($urandom);
      step("random");
    end
    $display("test_random: frames=%0d", m_fc);
  endtask

  task automatic test_async_reset();
    mode = 2'd1;
    run  = 1'b1;
    for (int i = 0; i < 2 * FRAME && !(m_act && m_pos == 3); i++) step("ar_seek");
    step("ar_active");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec() !== IDLE_VEC) begin
      bad++;
      $display("FAIL async_reset got=%h expected=%h", dut_vec(), IDLE_VEC);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    run = 1'b1;
    model_reset();
    step("ar_rel1");
    step("ar_rel2");
    total++;
    if (frame_start !== 1'b1 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL ar_restart got=%0b/%0d expected=1/0", frame_start, frame_cnt);
    end
    repeat (FRAME) step("ar_run");
    $display("test_async_reset: done");
  endtask

  initial begin
    test_reset();
    test_bars();
    test_drain();
    test_mode_change();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
